// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and 100 MHz default timing for the button conditioner
package btn_pkg;
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 2000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- 2-FF synchronizer, debounce FSM and auto-repeat
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_W = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);
  logic             meta, sync;
  btn_state_t       state, state_n;
  logic [DB_W-1:0]  db_cnt, db_n;
  logic [RP_W-1:0]  rp_cnt, rp_n, rp_lim;
  logic             first_rep, first_n, level_n, press_n, rel_n;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      state     <= RELEASED;
      db_cnt    <= '0;
      rp_cnt    <= '0;
      first_rep <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
    end else begin
      meta      <= btn;
      sync      <= meta;
      state     <= state_n;
      db_cnt    <= db_n;
      rp_cnt    <= rp_n;
      first_rep <= first_n;
      level     <= level_n;
      press     <= press_n;
      rel       <= rel_n;
    end
  end
  always_comb begin
    state_n = state;
    db_n    = db_cnt;
    rp_n    = rp_cnt;
    first_n = first_rep;
    press_n = 1'b0;
    rel_n   = 1'b0;
    rp_lim  = first_rep ? RD_LAST : RP_LAST;
    case (state)
      RELEASED: if (sync) begin
        state_n = PRESS_CHK;
        db_n    = '0;
      end
      PRESS_CHK: if (!sync) state_n = RELEASED;
      else if (db_cnt == DB_LAST) begin
        state_n = PRESSED;
        press_n = 1'b1;
        rp_n    = '0;
        first_n = 1'b1;
      end else db_n = db_cnt + DB_W'(1);
      // rp_cnt is held across a release check so a rejected glitch resumes the hold timer
      PRESSED: if (!sync) begin
        state_n = RELEASE_CHK;
        db_n    = '0;
      end else if (rp_cnt != rp_lim) rp_n = rp_cnt + RP_W'(1);
      else if (repeat_en) begin
        press_n = 1'b1;
        rp_n    = '0;
        first_n = 1'b0;
      end
      RELEASE_CHK: if (sync) state_n = PRESSED;
      else if (db_cnt == DB_LAST) begin
        state_n = RELEASED;
        rel_n   = 1'b1;
      end else db_n = db_cnt + DB_W'(1);
      default: state_n = RELEASED;
    endcase
    level_n = (state_n == PRESSED) || (state_n == RELEASE_CHK);
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: independent debounce/auto-repeat conditioning of N_BTN raw pushbuttons
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] usr_btn,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn      (usr_btn[i]),
      .repeat_en(repeat_en[i]),
      .level    (btn_level[i]),
      .press    (btn_press[i]),
      .rel      (btn_release[i])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of press/bounce/glitch/repeat/reset/simultaneous behaviour
module tb_btn_conditioner;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] usr_btn, repeat_en, btn_level, btn_press, btn_release;
  int passed = 0, failed = 0, total = 0;

  btn_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .usr_btn(usr_btn), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // advance past the next rising edge; inputs set afterwards are sampled at the following edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    usr_btn   = 4'b0000;
    repeat_en = 4'b0000;
    tick(3);
    chk("reset_level", btn_level, 4'b0000);
    chk("reset_press", btn_press, 4'b0000);
    chk("reset_release", btn_release, 4'b0000);
    reset_n = 1'b1;
    tick(2);

    usr_btn = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk($sformatf("clean_press_%0d", k), btn_press, (k == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("clean_level_%0d", k), btn_level, (k >= 6) ? 4'b0001 : 4'b0000);
    end
    usr_btn = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk($sformatf("clean_rel_%0d", k), btn_release, (k == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("clean_rel_level_%0d", k), btn_level, (k < 6) ? 4'b0001 : 4'b0000);
    end
    tick(2);

    for (int k = 0; k < 20; k++) begin
      usr_btn = (k < 8 && ((k / 2) % 2 == 0)) ? 4'b0010 : 4'b0000;
      tick(1);
      chk($sformatf("bounce_%0d", k), btn_level | btn_press | btn_release, 4'b0000);
    end

    usr_btn = 4'b0100;
    tick(8);
    chk("glitch_pressed_level", btn_level, 4'b0100);
    for (int k = 0; k < 12; k++) begin
      usr_btn = (k < 3) ? 4'b0000 : 4'b0100;
      tick(1);
      chk($sformatf("glitch_level_%0d", k), btn_level, 4'b0100);
      chk($sformatf("glitch_pulses_%0d", k), btn_press | btn_release, 4'b0000);
    end
    usr_btn = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk($sformatf("glitch_rel_%0d", k), btn_release, (k == 6) ? 4'b0100 : 4'b0000);
      chk($sformatf("glitch_rel_level_%0d", k), btn_level, (k < 6) ? 4'b0100 : 4'b0000);
    end
    tick(2);

    repeat_en = 4'b1000;
    usr_btn   = 4'b1000;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      chk($sformatf("repeat_on_%0d", k), btn_press,
          (k == 6 || k == 26 || k == 34 || k == 42) ? 4'b1000 : 4'b0000);
    end
    usr_btn = 4'b0000;
    tick(12);
    chk("repeat_on_released", btn_level, 4'b0000);
    repeat_en = 4'b0000;
    usr_btn   = 4'b1000;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      chk($sformatf("repeat_off_%0d", k), btn_press, (k == 6) ? 4'b1000 : 4'b0000);
    end
    usr_btn = 4'b0000;
    tick(12);
    chk("repeat_off_released", btn_level, 4'b0000);

    usr_btn = 4'b0001;
    tick(10);
    chk("midhold_level", btn_level, 4'b0001);
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      chk($sformatf("midhold_reset_%0d", k), btn_level | btn_press | btn_release, 4'b0000);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk($sformatf("post_reset_press_%0d", k), btn_press, (k == 6) ? 4'b0001 : 4'b0000);
    end
    chk("post_reset_level", btn_level, 4'b0001);
    usr_btn = 4'b0000;
    tick(12);

    usr_btn = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk($sformatf("simul_press_%0d", k), btn_press, (k == 6) ? 4'b1111 : 4'b0000);
    end
    chk("simul_level", btn_level, 4'b1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
